// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller and its datapath.
// Latency: none (constants and types only).
// Backpressure: none.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_EXE   = 4'd2,
    S_MEMRD = 4'd3,
    S_MEMWR = 4'd4,
    S_WB    = 4'd5,
    S_BR    = 4'd6,
    S_JMP   = 4'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;

  localparam logic [1:0] WR_RT    = 2'b00;
  localparam logic [1:0] WR_RD    = 2'b01;
  localparam logic [1:0] WR_RA    = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;

  // Instruction class steers the FSM path after decode.
  typedef enum logic [2:0] {
    C_BAD = 3'd0,
    C_ALU = 3'd1,
    C_LW  = 3'd2,
    C_SW  = 3'd3,
    C_BEQ = 3'd4,
    C_JMP = 3'd5
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       ext_op;
    logic [1:0] npc_op;
    logic [1:0] wr_sel;
    logic [1:0] wd_sel;
    logic       link;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct to control-field decoder for the multi-cycle controller.
// Latency: purely combinational.
// Backpressure: none.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // Map each supported encoding to its class and datapath selects.
  always_comb begin
    dec = '{cls: C_BAD, alu_op: ALU_ADD, alu_src: 1'b0, ext_op: 1'b0,
            npc_op: NPC_PC4, wr_sel: WR_RT, wd_sel: WD_ALU, link: 1'b0};
    case (op)
      OP_RTYPE: begin
        dec.wr_sel = WR_RD;
        case (funct)
          FN_ADDU: dec.cls = C_ALU;
          FN_SUBU: begin dec.cls = C_ALU; dec.alu_op = ALU_SUB; end
          FN_SLT:  begin dec.cls = C_ALU; dec.alu_op = ALU_SLT; end
          FN_JR:   begin dec.cls = C_JMP; dec.npc_op = NPC_JR;  end
          default: dec.cls = C_BAD;
        endcase
      end
      OP_ADDIU: begin dec.cls = C_ALU; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
      OP_ORI:   begin dec.cls = C_ALU; dec.alu_src = 1'b1; dec.alu_op = ALU_OR;  end
      OP_LUI:   begin dec.cls = C_ALU; dec.alu_src = 1'b1; dec.alu_op = ALU_LUI; end
      OP_LW: begin
        dec.cls = C_LW; dec.alu_src = 1'b1; dec.ext_op = 1'b1; dec.wd_sel = WD_MEM;
      end
      OP_SW:    begin dec.cls = C_SW; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
      // Branch offset is signed; the compare itself is a subtract.
      OP_BEQ:   begin dec.cls = C_BEQ; dec.alu_op = ALU_SUB; dec.ext_op = 1'b1; dec.npc_op = NPC_BR; end
      OP_J:     begin dec.cls = C_JMP; dec.npc_op = NPC_JMP; end
      OP_JAL: begin
        dec.cls = C_JMP; dec.npc_op = NPC_JMP; dec.link = 1'b1;
        dec.wr_sel = WR_RA; dec.wd_sel = WD_PC4;
      end
      default: dec.cls = C_BAD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FSM sequencing plus output gating.
// Latency: beq/j/jal/jr 3 cycles, ALU and sw 4, lw 5, plus memory wait cycles.
// Backpressure: mem_rdy=0 stalls FETCH, MEMRD and MEMWR in place.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] NPCOp,
  output logic       RFWr,
  output logic       DMWr,
  output logic [2:0] ALUOp,
  output logic       ALUSrc,
  output logic       EXTOp,
  output logic [1:0] WRSel,
  output logic [1:0] WDSel,
  output logic [3:0] state
);

  state_e     st;
  logic [5:0] op_q;
  logic [5:0] funct_q;
  logic [5:0] dec_op;
  logic [5:0] dec_funct;
  dec_t       dec;

  // DCD decides on the live IR fields; later states use the copy taken in DCD.
  assign dec_op    = (st == S_DCD) ? op    : op_q;
  assign dec_funct = (st == S_DCD) ? funct : funct_q;

  mc_decode u_decode (
    .op    (dec_op),
    .funct (dec_funct),
    .dec   (dec)
  );

  // State sequencing and op/funct capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      case (st)
        S_FETCH: if (mem_rdy) st <= S_DCD;
        S_DCD: begin
          op_q    <= op;
          funct_q <= funct;
          case (dec.cls)
            C_ALU, C_LW, C_SW: st <= S_EXE;
            C_BEQ:             st <= S_BR;
            C_JMP:             st <= S_JMP;
            default:           st <= S_FETCH;
          endcase
        end
        S_EXE: begin
          case (dec.cls)
            C_LW:    st <= S_MEMRD;
            C_SW:    st <= S_MEMWR;
            default: st <= S_WB;
          endcase
        end
        S_MEMRD: if (mem_rdy) st <= S_WB;
        S_MEMWR: if (mem_rdy) st <= S_FETCH;
        default: st <= S_FETCH;
      endcase
    end
  end

  // Outputs follow state and decoded fields; reset forces every strobe low at once.
  // ALU selects stay applied from EXE through WB so an unregistered ALU result stays valid.
  always_comb begin
    PCWr   = 1'b0;
    IRWr   = 1'b0;
    NPCOp  = NPC_PC4;
    RFWr   = 1'b0;
    DMWr   = 1'b0;
    ALUOp  = ALU_ADD;
    ALUSrc = 1'b0;
    EXTOp  = 1'b0;
    WRSel  = WR_RT;
    WDSel  = WD_ALU;
    if (rst) begin
      case (st)
        S_FETCH: begin
          IRWr = mem_rdy;
          PCWr = mem_rdy;
        end
        S_EXE, S_MEMRD, S_MEMWR, S_WB: begin
          ALUOp  = dec.alu_op;
          ALUSrc = dec.alu_src;
          EXTOp  = dec.ext_op;
          DMWr   = (st == S_MEMWR);
          if (st == S_WB) begin
            RFWr  = 1'b1;
            WRSel = dec.wr_sel;
            WDSel = dec.wd_sel;
          end
        end
        S_BR: begin
          ALUOp = ALU_SUB;
          EXTOp = dec.ext_op;
          NPCOp = NPC_BR;
          PCWr  = zero;
        end
        S_JMP: begin
          PCWr  = 1'b1;
          NPCOp = dec.npc_op;
          if (dec.link) begin
            RFWr  = 1'b1;
            WRSel = dec.wr_sel;
            WDSel = dec.wd_sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: instruction-level reference model plus directed pins.
// Latency: n/a.
// Backpressure: mem_rdy wait cycles are randomised in FETCH, MEMRD and MEMWR.
module tb_mc_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_rdy;
  logic       PCWr, IRWr, RFWr, DMWr, ALUSrc, EXTOp;
  logic [1:0] NPCOp, WRSel, WDSel;
  logic [2:0] ALUOp;
  logic [3:0] state;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp), .RFWr(RFWr), .DMWr(DMWr),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .EXTOp(EXTOp), .WRSel(WRSel), .WDSel(WDSel),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwr;
    logic       irwr;
    logic [1:0] npc;
    logic       rfwr;
    logic       dmwr;
    logic [2:0] alu;
    logic       asrc;
    logic       ext;
    logic [1:0] wrs;
    logic [1:0] wds;
  } out_t;

  localparam int K_BAD = 0, K_ALU = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JMP = 5;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       rtype;
    logic [2:0] cls;
    logic [2:0] alu;
    logic       asrc;
    logic       ext;
    logic [1:0] npc;
    logic [1:0] wrs;
    logic [1:0] wds;
    logic       link;
  } ins_t;

  ins_t tbl [0:11];
  ins_t bad_ins;
  out_t dut_o, exp_o;
  out_t obs [$];
  bit   exp_vld = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [5:0] cur_op = 6'h00;
  logic [5:0] cur_fn = 6'h00;

  assign dut_o = {state, PCWr, IRWr, NPCOp, RFWr, DMWr, ALUOp, ALUSrc, EXTOp, WRSel, WDSel};

  function automatic ins_t mk(input logic [5:0] o, input logic [5:0] f, input logic r,
                              input int c, input logic [2:0] a, input logic s, input logic e,
                              input logic [1:0] n, input logic [1:0] w, input logic [1:0] d,
                              input logic l);
    ins_t t;
    t.op = o; t.fn = f; t.rtype = r; t.cls = 3'(c); t.alu = a; t.asrc = s; t.ext = e;
    t.npc = n; t.wrs = w; t.wds = d; t.link = l;
    return t;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("st=%0d pc=%b ir=%b npc=%b rf=%b dm=%b alu=%b src=%b ext=%b wr=%b wd=%b",
                     o.st, o.pcwr, o.irwr, o.npc, o.rfwr, o.dmwr, o.alu, o.asrc, o.ext, o.wrs, o.wds);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_o(input string name, input out_t act, input out_t req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, fmt(act), fmt(req));
    end
  endtask

  // Every meaningful cycle is compared against the model's expectation.
  always @(negedge clk) begin
    if (exp_vld) begin
      check_o("cycle", dut_o, exp_o);
      obs.push_back(dut_o);
    end
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic out_t blank(input logic [3:0] s);
    out_t o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic out_t alu_fields(input logic [3:0] s, input ins_t t);
    out_t o = blank(s);
    o.alu = t.alu; o.asrc = t.asrc; o.ext = t.ext;
    return o;
  endfunction

  task automatic drive(input logic mr, input logic z, input out_t e);
    @(posedge clk);
    #1;
    op = cur_op; funct = cur_fn; mem_rdy = mr; zero = z;
    exp_o = e; exp_vld = 1'b1;
  endtask

  // Expands one instruction into its expected cycle-by-cycle outputs and drives it.
  task automatic run_instr(input ins_t t, input logic [5:0] o6, input logic [5:0] f6,
                           input int fw, input int mw, input logic z,
                           output int core, output int first);
    out_t e;
    core   = 0;
    first  = obs.size() + fw;
    cur_op = o6; cur_fn = f6;
    for (int i = 0; i < fw; i++) drive(1'b0, rbit(), blank(S_FETCH));
    e = blank(S_FETCH); e.pcwr = 1'b1; e.irwr = 1'b1;
    drive(1'b1, rbit(), e); core++;
    drive(rbit(), rbit(), blank(S_DCD)); core++;
    if (t.cls == 3'(K_ALU) || t.cls == 3'(K_LW) || t.cls == 3'(K_SW)) begin
      drive(rbit(), rbit(), alu_fields(S_EXE, t)); core++;
      if (t.cls == 3'(K_LW)) begin
        for (int i = 0; i < mw; i++) drive(1'b0, rbit(), alu_fields(S_MEMRD, t));
        drive(1'b1, rbit(), alu_fields(S_MEMRD, t)); core++;
      end
      if (t.cls == 3'(K_SW)) begin
        e = alu_fields(S_MEMWR, t); e.dmwr = 1'b1;
        for (int i = 0; i < mw; i++) drive(1'b0, rbit(), e);
        drive(1'b1, rbit(), e); core++;
      end else begin
        e = alu_fields(S_WB, t); e.rfwr = 1'b1; e.wrs = t.wrs; e.wds = t.wds;
        drive(rbit(), rbit(), e); core++;
      end
    end else if (t.cls == 3'(K_BR)) begin
      e = blank(S_BR); e.alu = 3'b001; e.ext = t.ext; e.npc = 2'b01; e.pcwr = z;
      drive(rbit(), z, e); core++;
    end else if (t.cls == 3'(K_JMP)) begin
      e = blank(S_JMP); e.pcwr = 1'b1; e.npc = t.npc;
      if (t.link) begin e.rfwr = 1'b1; e.wrs = t.wrs; e.wds = t.wds; end
      drive(rbit(), rbit(), e); core++;
    end
    @(negedge clk);
    #1;
  endtask

  function automatic int count_st(input int from, input logic [3:0] s);
    int c = 0;
    for (int i = from; i < obs.size(); i++) if (obs[i].st == s) c++;
    return c;
  endfunction

  function automatic int count_en(input int from);
    int c = 0;
    for (int i = from; i < obs.size(); i++) c += int'(obs[i].pcwr | obs[i].rfwr | obs[i].dmwr);
    return c;
  endfunction

  function automatic bit valid_enc(input logic [5:0] o, input logic [5:0] f);
    for (int i = 0; i < 12; i++)
      if (tbl[i].op == o && (!tbl[i].rtype || tbl[i].fn == f)) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int   core, first, k, fw, mw;
    ins_t t;
    logic [5:0] o6, f6;

    tbl[0]  = mk(6'h00, 6'h21, 1, K_ALU, 3'b000, 0, 0, 2'b00, 2'b01, 2'b00, 0); // addu
    tbl[1]  = mk(6'h00, 6'h23, 1, K_ALU, 3'b001, 0, 0, 2'b00, 2'b01, 2'b00, 0); // subu
    tbl[2]  = mk(6'h00, 6'h2A, 1, K_ALU, 3'b011, 0, 0, 2'b00, 2'b01, 2'b00, 0); // slt
    tbl[3]  = mk(6'h09, 6'h00, 0, K_ALU, 3'b000, 1, 1, 2'b00, 2'b00, 2'b00, 0); // addiu
    tbl[4]  = mk(6'h0D, 6'h00, 0, K_ALU, 3'b010, 1, 0, 2'b00, 2'b00, 2'b00, 0); // ori
    tbl[5]  = mk(6'h0F, 6'h00, 0, K_ALU, 3'b100, 1, 0, 2'b00, 2'b00, 2'b00, 0); // lui
    tbl[6]  = mk(6'h23, 6'h00, 0, K_LW,  3'b000, 1, 1, 2'b00, 2'b00, 2'b01, 0); // lw
    tbl[7]  = mk(6'h2B, 6'h00, 0, K_SW,  3'b000, 1, 1, 2'b00, 2'b00, 2'b00, 0); // sw
    tbl[8]  = mk(6'h04, 6'h00, 0, K_BR,  3'b001, 0, 1, 2'b01, 2'b00, 2'b00, 0); // beq
    tbl[9]  = mk(6'h02, 6'h00, 0, K_JMP, 3'b000, 0, 0, 2'b10, 2'b00, 2'b00, 0); // j
    tbl[10] = mk(6'h03, 6'h00, 0, K_JMP, 3'b000, 0, 0, 2'b10, 2'b10, 2'b10, 1); // jal
    tbl[11] = mk(6'h00, 6'h08, 1, K_JMP, 3'b000, 0, 0, 2'b11, 2'b00, 2'b00, 0); // jr
    bad_ins = mk(6'h3F, 6'h00, 0, K_BAD, 3'b000, 0, 0, 2'b00, 2'b00, 2'b00, 0);

    // Reset state, with mem_rdy high to show FETCH strobes are suppressed.
    rst = 1'b0; mem_rdy = 1'b1; zero = 1'b0; op = 6'h00; funct = 6'h00;
    #3;
    check_o("reset_outputs", dut_o, blank(S_FETCH));
    @(posedge clk); #1;
    check_o("reset_after_edge", dut_o, blank(S_FETCH));
    @(posedge clk); #3;
    mem_rdy = 1'b0; rst = 1'b1;

    // addu $3,$1,$2 with no memory waits
    run_instr(tbl[0], 6'h00, 6'h21, 0, 0, 1'b0, core, first);
    check("addu_latency", 32'(core), 32'd4);
    check("addu_st_fetch", 32'(obs[first].st), 32'd0);
    check("addu_st_dcd", 32'(obs[first+1].st), 32'd1);
    check("addu_st_exe", 32'(obs[first+2].st), 32'd2);
    check("addu_st_wb", 32'(obs[first+3].st), 32'd5);
    check("addu_wb_rfwr_wrsel_alu", {obs[first+3].rfwr, obs[first+3].wrs, obs[first+3].alu}, 32'b1_01_000);

    // lw with two wait cycles in MEMRD
    run_instr(tbl[6], 6'h23, 6'h15, 1, 2, 1'b0, core, first);
    check("lw_latency", 32'(core), 32'd5);
    check("lw_memrd_cycles", 32'(count_st(first, S_MEMRD)), 32'd3);
    check("lw_wb_cycles", 32'(count_st(first, S_WB)), 32'd1);
    check("lw_wb_wdsel_rfwr", {obs[obs.size()-1].wds, obs[obs.size()-1].rfwr}, 32'b01_1);

    // sw with one wait: DMWr held through the wait and the completing cycle
    run_instr(tbl[7], 6'h2B, 6'h00, 0, 1, 1'b0, core, first);
    check("sw_latency", 32'(core), 32'd4);
    check("sw_dmwr_cycles", 32'(count_en(first + 2)), 32'd2);

    // beq taken, then not taken
    run_instr(tbl[8], 6'h04, 6'h00, 0, 0, 1'b1, core, first);
    check("beq_latency", 32'(core), 32'd3);
    check("beq_taken_pcwr_npc", {obs[obs.size()-1].pcwr, obs[obs.size()-1].npc}, 32'b1_01);
    run_instr(tbl[8], 6'h04, 6'h00, 2, 0, 1'b0, core, first);
    check("beq_not_taken_pcwr", 32'(obs[obs.size()-1].pcwr), 32'd0);

    // jal then jr
    run_instr(tbl[10], 6'h03, 6'h2A, 0, 0, 1'b0, core, first);
    check("jal_latency", 32'(core), 32'd3);
    check("jal_outputs", {obs[obs.size()-1].pcwr, obs[obs.size()-1].npc, obs[obs.size()-1].rfwr,
                          obs[obs.size()-1].wrs, obs[obs.size()-1].wds}, 32'b1_10_1_10_10);
    run_instr(tbl[11], 6'h00, 6'h08, 0, 0, 1'b0, core, first);
    check("jr_npc_rfwr", {obs[obs.size()-1].npc, obs[obs.size()-1].rfwr}, 32'b11_0);

    // undefined opcode 6'h3F returns to FETCH with no write strobes
    run_instr(bad_ins, 6'h3F, 6'h21, 0, 0, 1'b0, core, first);
    check("undef_latency", 32'(core), 32'd2);
    cur_op = 6'h00; cur_fn = 6'h00;
    drive(1'b0, 1'b0, blank(S_FETCH));
    @(negedge clk); #1;
    check("undef_no_strobes", 32'(count_en(first + 1)), 32'd0);

    // Reset asserted during EXE of addu
    cur_op = 6'h00; cur_fn = 6'h21;
    begin
      out_t e;
      e = blank(S_FETCH); e.pcwr = 1'b1; e.irwr = 1'b1;
      drive(1'b1, 1'b0, e);
      drive(1'b0, 1'b0, blank(S_DCD));
      drive(1'b1, 1'b0, alu_fields(S_EXE, tbl[0]));
    end
    @(negedge clk); #2;
    exp_vld = 1'b0; mem_rdy = 1'b1; rst = 1'b0;
    #1;
    check_o("rst_mid_exe_async", dut_o, blank(S_FETCH));
    @(posedge clk); #1;
    check_o("rst_mid_exe_held", dut_o, blank(S_FETCH));
    #2;
    mem_rdy = 1'b0; rst = 1'b1;
    drive(1'b0, 1'b0, blank(S_FETCH));
    drive(1'b0, 1'b0, blank(S_FETCH));
    run_instr(tbl[0], 6'h00, 6'h21, 0, 0, 1'b0, core, first);
    check("post_reset_addu_latency", 32'(core), 32'd4);

    // Randomised instruction stream
    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 13);
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      if (k < 12) begin
        t  = tbl[k];
        o6 = t.op;
        f6 = t.rtype ? t.fn : 6'($urandom);
      end else if (k == 12) begin
        t  = bad_ins;
        f6 = 6'($urandom);
        do o6 = 6'($urandom); while (o6 == 6'h00 || valid_enc(o6, f6));
      end else begin
        t  = bad_ins;
        o6 = 6'h00;
        do f6 = 6'($urandom); while (valid_enc(o6, f6));
      end
      run_instr(t, o6, f6, fw, mw, rbit(), core, first);
    end

    exp_vld = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
